dmem_responder: RTL



---
 rtl/dmem_responder_pkg.sv | 25 ++
 rtl/dmem_sram_array.sv | 34 +++
 rtl/dmem_responder.sv | 144 ++++++++++++++
 3 files changed

// File: rtl/dmem_responder_pkg.sv
// Shared types for the data-memory responder: FSM states, request/response records
// and the width of the latency counter.
package riscv_defines;

    localparam int DMEM_LAT_W = 4;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } dmem_state_e;

    typedef struct packed {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  be;
    } dmem_req_t;

    typedef struct packed {
        logic [31:0] rdata;
        logic        err;
    } dmem_resp_t;

endpackage

// File: rtl/dmem_sram_array.sv
// Synchronous single-port word RAM with per-byte write enables and a registered read.
// A read during a write returns the previous contents of the word.
module dmem_sram_array
    import riscv_defines::*;
#(
    parameter int DEPTH = 4096,
    parameter int IDX_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             en,
    input  logic             we,
    input  logic [3:0]       be,
    input  logic [IDX_W-1:0] idx,
    input  logic [31:0]      wdata,
    output logic [31:0]      rdata
);

    logic [31:0] mem [DEPTH];

    // The read register doubles as the load holding register, so it only moves on enable.
    always_ff @(posedge clk) begin
        if (en) begin
            if (we) begin
                for (int i = 0; i < 4; i++) begin
                    if (be[i]) begin
                        mem[idx][8*i +: 8] <= wdata[8*i +: 8];
                    end
                end
            end
            rdata <= mem[idx];
        end
    end

endmodule

// File: rtl/dmem_responder.sv
// Data-memory responder: valid/ready load/store port onto a byte-writable SRAM with a
// fixed response latency. Defining DMEM_TOHOST_EN adds the sticky tohost mailbox.
module dmem_responder
    import riscv_defines::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h0001_0000,
    parameter int          DEPTH_WORDS = 4096,
    parameter int          LATENCY     = 1
`ifdef DMEM_TOHOST_EN
    ,
    parameter logic [31:0] TOHOST_ADDR = 32'h0000_1000
`endif
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    input  logic [3:0]  req_be,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_err
`ifdef DMEM_TOHOST_EN
    ,
    output logic        tohost_valid,
    output logic [31:0] tohost_data
`endif
);

    localparam int          IDX_W    = $clog2(DEPTH_WORDS);
    localparam logic [32:0] ADDR_END = {1'b0, BASE_ADDR} + 33'(4 * DEPTH_WORDS);

    dmem_req_t             req;
    dmem_state_e           state;
    dmem_resp_t            resp_q;
    logic [DMEM_LAT_W-1:0] cnt;
    logic                  sel_sram;
    logic                  accept;
    logic                  err;
    logic                  is_tohost;
    logic                  sram_en;
    logic [IDX_W-1:0]      idx;
    logic [31:0]           sram_rdata;
    logic [31:0]           hold_next;

    assign req       = '{we: req_we, addr: req_addr, wdata: req_wdata, be: req_be};
    assign req_ready = (state == IDLE);
    assign accept    = req_valid && req_ready;

    // Fault decode and SRAM index; the bound check uses 33 bits so the end address cannot wrap.
    always_comb begin
        logic range_err;
        range_err = (req.addr[1:0] != 2'b00)
                 || ({1'b0, req.addr} < {1'b0, BASE_ADDR})
                 || ({1'b0, req.addr} >= ADDR_END)
                 || (req.we && req.be == 4'h0);
`ifdef DMEM_TOHOST_EN
        is_tohost = (req.addr == TOHOST_ADDR);
        err       = is_tohost ? (req.we && req.be != 4'hF) : range_err;
        hold_next = (is_tohost && !req.we) ? tohost_data : 32'h0;
`else
        is_tohost = 1'b0;
        err       = range_err;
        hold_next = 32'h0;
`endif
        idx     = IDX_W'((req.addr - BASE_ADDR) >> 2);
        sram_en = accept && !err && !is_tohost;
    end

    dmem_sram_array #(
        .DEPTH (DEPTH_WORDS),
        .IDX_W (IDX_W)
    ) u_sram (
        .clk   (clk),
        .en    (sram_en),
        .we    (req.we),
        .be    (req.be),
        .idx   (idx),
        .wdata (req.wdata),
        .rdata (sram_rdata)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state      <= IDLE;
            cnt        <= '0;
            resp_valid <= 1'b0;
            resp_q     <= '0;
            sel_sram   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        resp_q   <= '{rdata: hold_next, err: err};
                        sel_sram <= !req.we && !err && !is_tohost;
                        if (LATENCY == 1) begin
                            state      <= RESP;
                            resp_valid <= 1'b1;
                        end else begin
                            state <= WAIT;
                            cnt   <= DMEM_LAT_W'(LATENCY - 2);
                        end
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        state      <= RESP;
                        resp_valid <= 1'b1;
                    end else begin
                        cnt <= cnt - DMEM_LAT_W'(1);
                    end
                end
                RESP: begin
                    if (resp_ready) begin
                        state      <= IDLE;
                        resp_valid <= 1'b0;
                        resp_q     <= '0;
                        sel_sram   <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign resp_err   = resp_q.err;
    assign resp_rdata = sel_sram ? sram_rdata : resp_q.rdata;

`ifdef DMEM_TOHOST_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            tohost_valid <= 1'b0;
            tohost_data  <= 32'h0;
        end else if (accept && is_tohost && req.we && !err) begin
            tohost_valid <= 1'b1;
            tohost_data  <= req.wdata;
        end
    end
`endif

endmodule
